fifo_ram_ctrl: RTL and testbench
================================

Name: fifo_ram_ctrl

Overview:
- Pointer and flag controller that turns one SyncRAMDualPort instance into a first-word-fall-through FIFO for profiling-counter samples.
- RAM port A is the write port. RAM port B is the read port, with a combinational read.
- Adds a registered output stage, valid/ready handshakes on both sides, occupancy level, almost-full threshold and sticky error flags.
- Sits between the counter sampling logic (producer) and the readout/drain logic (consumer).

Parameters:
- ADDR_WIDTH, 4: RAM address width. RAM capacity DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: sample width. Must match the RAM.
- AF_THRESH, DEPTH-2: almostFull asserts when level >= AF_THRESH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wrValid  in  1  producer has a sample.
- wrData  in  DATA_WIDTH  sample.
- wrReady  out  1  controller accepts a sample this cycle.
- rdValid  out  1  rdData holds a valid sample.
- rdData  out  DATA_WIDTH  registered head sample.
- rdReady  in  1  consumer takes rdData this cycle.
- level  out  ADDR_WIDTH+1  entries held (RAM plus output register).
- almostFull  out  1  level >= AF_THRESH.
- overflow  out  1  sticky: wrValid seen while wrReady=0.
- underflow  out  1  sticky: rdReady seen while rdValid=0.
- ramAddrA  out  ADDR_WIDTH  write pointer (low bits).
- ramWriteA  out  1  RAM write strobe.
- ramWriteDataA  out  DATA_WIDTH  equals wrData.
- ramAddrB  out  ADDR_WIDTH  read pointer (low bits).
- ramWriteB  out  1  tied 0.
- ramReadDataB  in  DATA_WIDTH  combinational RAM read data at ramAddrB.

Behaviour:
- Reset (rst_n=0, asynchronous): wrPtr, rdPtr, ramCount, rdValid, rdData, overflow and underflow all 0. Hence level=0, wrReady=1, almostFull=0.
- Pointers are ADDR_WIDTH+1 bits. The RAM uses the low bits; the MSB gives natural wrap-around.
- ramCount = wrPtr - rdPtr, modulo 2^(ADDR_WIDTH+1). Range 0..DEPTH.
- Write side:
  - wrReady = (ramCount != DEPTH) & ~flush. Combinational; does not depend on the same-cycle read.
  - A write fires when wrValid & wrReady. Then ramWriteA=1 and wrPtr++ at the edge.
- Output stage:
  - load = (ramCount != 0) & (~rdValid | rdReady) & ~flush.
  - On load at the edge: rdData <= ramReadDataB, rdPtr++, rdValid <= 1.
  - On rdReady & rdValid without load: rdValid <= 0.
  - No same-cycle bypass. A sample written at edge N is loaded at edge N+1, so rdValid rises 2 cycles after the write cycle when the FIFO is empty.
- Simultaneous write and load: both pointers advance and ramCount is unchanged.
  - Same-address read/write cannot occur: a load needs ramCount >= 1, which means rdPtr != wrPtr.
- Full: ramCount = DEPTH, so wrReady=0 even if a pop happens that cycle. The freed slot is usable the next cycle.
- Capacity: level = ramCount + rdValid. Maximum level = DEPTH + 1.
- Steady state: one write and one pop per cycle is sustainable once primed.
- flush=1:
  - At the edge: wrPtr=rdPtr=0, rdValid=0, overflow=underflow=0.
  - Writes, loads and pops that cycle are ignored. Flush has priority.
  - rdData holds its stale value, which is don't-care.
- Sticky flags:
  - overflow sets on wrValid & ~wrReady & ~flush.
  - underflow sets on rdReady & ~rdValid & ~flush.
  - Both clear only on reset or flush.
- Reset mid-operation: everything clears immediately and asynchronously. RAM contents are not cleared and are irrelevant.
- All outputs except wrReady, the ram* outputs and almostFull are registered.

Test Plan:
- DEPTH=4, empty. Write 0xA1 with rdReady=0 → rdValid=1 two cycles after the write cycle, rdData=0xA1, level=1.
- Write 5 words 0x10..0x14 with rdReady=0 → wrReady=0 after the 5th accept, level=5, almostFull=1 from level=2. Extra wrValid → overflow=1. Drain → 0x10..0x14 in order.
- Prime 2 words, then wrValid=rdReady=1 continuously for 20 cycles with an incrementing pattern → one pop per cycle, no gaps, level constant at 2, pointers wrap at least 4 times, data matches.
- Full FIFO, pop and write in the same cycle → write refused that cycle (wrReady=0), accepted the next cycle, order preserved.
- Fill 3 words, assert flush together with wrValid and rdReady → next cycle level=0, rdValid=0, flags=0. A following write of 0x55 pops as 0x55.
- Hold rdReady=1 while empty → underflow=1. Then pulse rst_n low mid-stream with 3 words queued → all outputs return to reset values immediately, before any clock edge.

Source files
------------

// File: rtl/fifo_ram_ctrl_if.sv
// rtl/fifo_ram_ctrl_if.sv - producer/consumer handshake bundle for the FIFO RAM controller
interface fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wrValid;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wrReady;
  logic                  rdValid;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdReady;

  // Environment side: drives samples in and drains samples out
  modport master (
    output wrValid, wrData, rdReady,
    input  wrReady, rdValid, rdData
  );

  // Controller side
  modport slave (
    input  wrValid, wrData, rdReady,
    output wrReady, rdValid, rdData
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - FWFT FIFO pointer/flag controller around a dual-port RAM
module fifo_ram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  fifo_ram_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almostFull_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [ADDR_WIDTH-1:0] ramAddrA_o,
  output logic                  ramWriteA_o,
  output logic [DATA_WIDTH-1:0] ramWriteDataA_o,
  output logic [ADDR_WIDTH-1:0] ramAddrB_o,
  output logic                  ramWriteB_o,
  input  logic [DATA_WIDTH-1:0] ramReadDataB_i
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AF_T    = PW'(AF_THRESH);

  // Pointers carry one extra MSB so full (DEPTH) and empty (0) are distinguishable
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [PW-1:0] ram_count;
  logic [PW-1:0] ram_count_d;
  logic          wr_ready;
  logic          wr_fire;
  logic          load;

  assign ram_count = wr_ptr_q - rd_ptr_q;
  // Full refuses writes even when a pop happens in the same cycle
  assign wr_ready  = (ram_count != DEPTH_C) && !flush_i;
  assign wr_fire   = bus.wrValid && wr_ready;
  // Refill the output register when it is empty or being drained this cycle
  assign load      = (ram_count != '0) && (!rd_valid_q || bus.rdReady) && !flush_i;

  // Next-state for pointers, output stage, level and sticky flags; flush wins over everything
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_data_d  = ramReadDataB_i;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end else if (bus.rdReady && rd_valid_q) begin
        rd_valid_d = 1'b0;
      end
      if (bus.wrValid && !wr_ready) begin
        ovf_d = 1'b1;
      end
      if (bus.rdReady && !rd_valid_q) begin
        unf_d = 1'b1;
      end
    end
    ram_count_d = wr_ptr_d - rd_ptr_d;
    level_d     = ram_count_d + {{(PW-1){1'b0}}, rd_valid_d};
  end

  // State registers with asynchronous clear; rdData keeps its (don't-care) value on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.wrReady     = wr_ready;
  assign bus.rdValid     = rd_valid_q;
  assign bus.rdData      = rd_data_q;
  assign level_o         = level_q;
  assign almostFull_o    = (level_q >= AF_T);
  assign overflow_o      = ovf_q;
  assign underflow_o     = unf_q;
  assign ramAddrA_o      = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ramWriteA_o     = wr_fire;
  assign ramWriteDataA_o = bus.wrData;
  assign ramAddrB_o      = rd_ptr_q[ADDR_WIDTH-1:0];
  assign ramWriteB_o     = 1'b0;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - scoreboard bench for fifo_ram_ctrl with a behavioural FIFO model
module tb_fifo_ram_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int AFT   = DEPTH - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic [AW:0]   level;
  logic          almost_full, overflow, underflow;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_write_a, ram_write_b;
  logic [DW-1:0] ram_wdata_a, ram_rdata_b;

  fifo_ram_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AFT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .bus            (bus.slave),
    .level_o        (level),
    .almostFull_o   (almost_full),
    .overflow_o     (overflow),
    .underflow_o    (underflow),
    .ramAddrA_o     (ram_addr_a),
    .ramWriteA_o    (ram_write_a),
    .ramWriteDataA_o(ram_wdata_a),
    .ramAddrB_o     (ram_addr_b),
    .ramWriteB_o    (ram_write_b),
    .ramReadDataB_i (ram_rdata_b)
  );

  // Dual-port RAM: synchronous write on A, combinational read on B
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_write_a) ram[ram_addr_a] <= ram_wdata_a;
  assign ram_rdata_b = ram[ram_addr_b];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: sb_q is every accepted sample in order; m_ram/m_val split it into RAM part and output register
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_ram[$];
  bit m_val, m_ovf, m_unf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ram.delete();
    sb_q.delete();
    m_val = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check_status();
    int lvl;
    lvl = m_ram.size() + int'(m_val);
    chk("rd_valid", bus.rdValid, m_val);
    chk("level", level, lvl);
    chk("almost_full", almost_full, lvl >= AFT);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance the model at posedge
  task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    bit ready, load;
    logic [DW-1:0] tmp;
    bus.wrValid = wv;
    bus.wrData  = wd;
    bus.rdReady = rr;
    flush       = fl;
    #1;
    ready = (m_ram.size() != DEPTH) && !fl;
    chk("wr_ready", bus.wrReady, ready);
    chk("ram_write_a", ram_write_a, wv && ready);
    chk("ram_write_b", ram_write_b, 1'b0);
    if (wv && ready) sb_q.push_back(wd);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (wv && !ready) m_ovf = 1;
      if (rr && !m_val) m_unf = 1;
      load = (m_ram.size() != 0) && (!m_val || rr);
      if (load) begin
        tmp   = m_ram.pop_front();
        m_val = 1;
      end else if (rr && m_val) begin
        m_val = 0;
      end
      if (wv && ready) m_ram.push_back(wd);
    end
    @(negedge clk);
    check_status();
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rr, 1'b0);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before any clock edge
  task automatic async_reset();
    bus.wrValid = 0;
    bus.rdReady = 0;
    flush       = 0;
    #2 rst_n = 0;
    #1;
    model_clear();
    chk("rst_wr_ready", bus.wrReady, 1'b1);
    check_status();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: consumes the scoreboard head whenever the DUT completes a read handshake
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    #4;
    if (rst_n && !flush && bus.rdValid && bus.rdReady) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: got %0h with no sample expected at %0t", bus.rdData, $time);
      end else begin
        exp_d = sb_q.pop_front();
        n_cmp--;
        chk("rd_data", bus.rdData, exp_d);
      end
    end
  end

  initial begin
    rst_n       = 0;
    flush       = 0;
    bus.wrValid = 0;
    bus.wrData  = '0;
    bus.rdReady = 0;
    model_clear();
    @(negedge clk);
    chk("rst_wr_ready", bus.wrReady, 1'b1);
    check_status();
    @(negedge clk);
    rst_n = 1;

    // Single write, output appears two cycles later, then drain
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Fill past capacity, overflow, drain in order
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h10 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'hEE, 1'b0, 1'b0);
    idle(6, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Prime two, then continuous streaming with pointer wrap
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h101, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h200 + i, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Full: pop and write together is refused, accepted on the next cycle
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h300 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'h3A0, 1'b1, 1'b0);
    cycle(1'b1, 32'h3A0, 1'b0, 1'b0);
    idle(7, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Flush with write and read pending, then reuse
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'h4FF, 1'b1, 1'b1);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Underflow, then asynchronous reset with data queued
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + i, 1'b0, 1'b0);
    async_reset();
    idle(2, 1'b0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0);
    end

    // Final drain: every accepted sample must have come out
    idle(DEPTH + 3, 1'b1);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
